// File: rtl/ita_disp_pkg.sv
// Shared character codes, segment constants and FSM state encoding for the
// ita_scroll14 14-segment scrolling display driver.
package ita_disp_pkg;

    // Character codes: SPACE=0, A..Z=1..26, '0'..'9'=27..36, 37..63 blank.
    localparam logic [5:0] CH_SPACE  = 6'd0;
    localparam logic [5:0] CH_A      = 6'd1;
    localparam logic [5:0] CH_Z      = 6'd26;
    localparam logic [5:0] CH_DIGIT0 = 6'd27;
    localparam logic [5:0] CH_DIGIT9 = 6'd36;

    // Segment order, bit13..bit0: a b c d e f g1 g2 h i j k l m.
    localparam logic [13:0] SEG_BLANK = 14'b00000000000000;
    localparam logic [13:0] SEG_A     = 14'b11101111000000;
    localparam logic [13:0] SEG_P     = 14'b11001111000000;
    localparam logic [13:0] SEG_T     = 14'b10000000010010;

    typedef logic [0:0] state_t;
    localparam state_t IDLE = 1'b0;
    localparam state_t RUN  = 1'b1;

endpackage

// File: rtl/ita_font14.sv
// Combinational character-code to 14-segment pattern ROM.
module ita_font14
    import ita_disp_pkg::*;
(
    input  logic [5:0]  code,
    output logic [13:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (code)
            6'd1:  seg = SEG_A;
            6'd2:  seg = 14'b11110001010010;
            6'd3:  seg = 14'b10011100000000;
            6'd4:  seg = 14'b11110000010010;
            6'd5:  seg = 14'b10011110000000;
            6'd6:  seg = 14'b10001110000000;
            6'd7:  seg = 14'b10111101000000;
            6'd8:  seg = 14'b01101111000000;
            6'd9:  seg = 14'b10010000010010;
            6'd10: seg = 14'b01111000000000;
            6'd11: seg = 14'b00001110001100;
            6'd12: seg = 14'b00011100000000;
            6'd13: seg = 14'b01101100101000;
            6'd14: seg = 14'b01101100100100;
            6'd15: seg = 14'b11111100000000;
            6'd16: seg = SEG_P;
            6'd17: seg = 14'b11111100000100;
            6'd18: seg = 14'b11001111000100;
            6'd19: seg = 14'b10110111000000;
            6'd20: seg = SEG_T;
            6'd21: seg = 14'b01111100000000;
            6'd22: seg = 14'b00001100001001;
            6'd23: seg = 14'b01101100000101;
            6'd24: seg = 14'b00000000101101;
            6'd25: seg = 14'b00000000101010;
            6'd26: seg = 14'b10010000001001;
            6'd27: seg = 14'b11111100001001;
            6'd28: seg = 14'b01100000001000;
            6'd29: seg = 14'b11011011000000;
            6'd30: seg = 14'b11110001000000;
            6'd31: seg = 14'b01100111000000;
            6'd32: seg = 14'b10110111000000;
            6'd33: seg = 14'b10111111000000;
            6'd34: seg = 14'b11100000000000;
            6'd35: seg = 14'b11111111000000;
            6'd36: seg = 14'b11110111000000;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/ita_scroll14.sv
// Multiplexed 14-segment driver with writable message buffer and scrolling window.
// Optional blink feature (blink input, BLINK_FRAMES) enabled by ITA_SCROLL_BLINK_EN.
module ita_scroll14
    import ita_disp_pkg::*;
#(
    parameter int N_DIGITS      = 12,
    parameter int MSG_LEN       = 32,
    parameter int REFRESH_DIV   = 1,
    parameter int SCROLL_FRAMES = 64
`ifdef ITA_SCROLL_BLINK_EN
    ,
    parameter int BLINK_FRAMES  = 32
`endif
)(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       scroll_en,
    input  logic [$clog2(MSG_LEN):0]   msg_len,
    input  logic                       wr_en,
    input  logic [$clog2(MSG_LEN)-1:0] wr_addr,
    input  logic [5:0]                 wr_char,
`ifdef ITA_SCROLL_BLINK_EN
    input  logic                       blink,
`endif
    output logic [N_DIGITS-1:0]        sel,
    output logic [13:0]                segm
);

    localparam int AW = $clog2(MSG_LEN);
    localparam int LW = AW + 1;
    localparam int IW = $clog2(N_DIGITS);
    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int FW = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;

    state_t        state;
    logic [PW-1:0] pre;
    logic [IW-1:0] idx;
    logic [AW-1:0] ptr, off;
    logic [FW-1:0] fcnt;
    logic [5:0]    mem [MSG_LEN];

    logic [LW-1:0] eff_len, ptr_p1, off_p1;
    logic [AW-1:0] ptr_s, off_s, ptr_inc, off_next;
    logic          tick, frame_end, scroll_step, blank;
    logic [13:0]   font_seg;

    // Out-of-range ptr/offset (after msg_len shrinks) are treated as 0 on use.
    assign eff_len     = (msg_len == '0 || msg_len > LW'(MSG_LEN)) ? LW'(MSG_LEN) : msg_len;
    assign ptr_s       = ({1'b0, ptr} >= eff_len) ? '0 : ptr;
    assign off_s       = ({1'b0, off} >= eff_len) ? '0 : off;
    assign ptr_p1      = {1'b0, ptr_s} + LW'(1);
    assign off_p1      = {1'b0, off_s} + LW'(1);
    assign ptr_inc     = (ptr_p1 == eff_len) ? '0 : AW'(ptr_p1);
    assign tick        = (state == RUN) && en && (pre == PW'(REFRESH_DIV - 1));
    assign frame_end   = tick && (idx == IW'(N_DIGITS - 1));
    assign scroll_step = scroll_en && (fcnt == FW'(SCROLL_FRAMES - 1));
    assign off_next    = scroll_step ? ((off_p1 == eff_len) ? '0 : AW'(off_p1)) : off_s;

    ita_font14 u_font (
        .code (mem[ptr_s]),
        .seg  (font_seg)
    );

`ifdef ITA_SCROLL_BLINK_EN
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    logic [BW-1:0] bcnt;
    logic          phase;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcnt  <= '0;
            phase <= 1'b0;
        end else if (!blink) begin
            bcnt  <= '0;
            phase <= 1'b0;
        end else if (frame_end) begin
            if (bcnt == BW'(BLINK_FRAMES - 1)) begin
                bcnt  <= '0;
                phase <= ~phase;
            end else begin
                bcnt <= bcnt + BW'(1);
            end
        end
    end

    assign blank = blink && phase;
`else
    assign blank = 1'b0;
`endif

    // Writes land at the clock edge, so a same-cycle display read sees the old char.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MSG_LEN; i++) mem[i] <= CH_SPACE;
        end else if (wr_en) begin
            mem[wr_addr] <= wr_char;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            pre   <= '0;
            idx   <= '0;
            ptr   <= '0;
            off   <= '0;
            fcnt  <= '0;
            sel   <= '0;
            segm  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    sel  <= '0;
                    segm <= '0;
                    pre  <= '0;
                    if (en) state <= RUN;
                end
                default: begin
                    if (!en) begin
                        state <= IDLE;
                        sel   <= '0;
                        segm  <= '0;
                    end else if (tick) begin
                        pre  <= '0;
                        sel  <= N_DIGITS'(1) << idx;
                        segm <= blank ? SEG_BLANK : font_seg;
                        if (frame_end) begin
                            idx <= '0;
                            ptr <= off_next;
                            off <= off_next;
                            if (scroll_en) fcnt <= scroll_step ? '0 : fcnt + FW'(1);
                        end else begin
                            idx <= idx + IW'(1);
                            ptr <= ptr_inc;
                        end
                    end else begin
                        pre <= pre + PW'(1);
                    end
                end
            endcase
        end
    end

endmodule
